rs_alu_station: RTL and testbench
=================================

Name: rs_alu_station

Overview:
- Reservation station feeding the integer ALU in the Tomasulo core.
- Buffers dispatched ALU/branch/JALR micro-ops until both source operands are known.
- Snoops the ALU CDB and the LSB CDB to wake up waiting operands.
- Each cycle, issues at most one ready entry to the ALU on the RS_* interface (flag, op, val1, val2, ROB index).

Parameters:
- RS_SIZE, 16, number of entries (power of two).
- RS_IDX_W, 4, log2(RS_SIZE).
- ROB_W, 4, ROB index width (matches `ROB_INDEX_RANGE`).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global ready; when low, all state is frozen.
- clear_in  in  1  mispredict flush of all entries.
- issue_flag_in  in  1  dispatcher writes a new entry this cycle.
- issue_op_in  in  6  ALU opcode.
- issue_qj_valid_in  in  1  operand j is pending; its ROB tag is in issue_qj_in.
- issue_qj_in  in  ROB_W  producer tag for operand j.
- issue_vj_in  in  32  value of operand j when not pending.
- issue_qk_valid_in  in  1  operand k is pending; its ROB tag is in issue_qk_in.
- issue_qk_in  in  ROB_W  producer tag for operand k.
- issue_vk_in  in  32  value of operand k when not pending (immediate for I-type).
- issue_dest_in  in  ROB_W  destination ROB index.
- full_out  out  1  no free entry.
- alu_cdb_flag_in  in  1  ALU broadcast valid.
- alu_cdb_val_in  in  32  ALU broadcast value.
- alu_cdb_idx_in  in  ROB_W  ALU broadcast ROB index.
- lsb_cdb_flag_in  in  1  LSB broadcast valid.
- lsb_cdb_val_in  in  32  LSB broadcast value.
- lsb_cdb_idx_in  in  ROB_W  LSB broadcast ROB index.
- RS_flag_out  out  1  ALU operation valid.
- RS_op_out  out  6  opcode.
- RS_val1_out  out  32  operand j.
- RS_val2_out  out  32  operand k.
- RS_idx_in_ROB_out  out  ROB_W  destination ROB index.

Behaviour:
- Entry state: busy, op, vj, vk, qj_valid, qj, qk_valid, qk, dest.
- Reset:
  - All busy=0 and all entry fields 0.
  - RS_flag_out=0; RS_op_out, RS_val1_out, RS_val2_out and RS_idx_in_ROB_out all 0.
  - full_out=0.
- Priority at each posedge:
  - rst.
  - Then !rdy: hold all state; RS_* outputs hold their values.
  - Then clear_in: same effect as reset.
  - Then normal operation.
- full_out is combinational: 1 when all RS_SIZE entries are busy at the start of the cycle.
- Issue while full_out=1 is a dispatcher error; the station ignores it and state is unchanged.
- Issue:
  - Writes the lowest-index entry that is non-busy at the start of the cycle.
  - An entry freed by selection in the same cycle is not reusable until the next cycle.
- Issue-time forwarding: if issue_qj_valid_in=1 and a CDB broadcasts the same tag this cycle, store vj=that value and qj_valid=0. Operand k is handled the same way.
- Wakeup:
  - For every busy entry with qj_valid=1: if qj matches alu_cdb_idx_in (with alu_cdb_flag_in=1), capture alu_cdb_val_in and clear qj_valid; otherwise check lsb_cdb_idx_in the same way.
  - Operand k is handled the same way.
  - Both CDBs may hit different operands of the same entry in the same cycle.
- Selection:
  - Candidates are entries that, at the start of the cycle, have busy=1, qj_valid=0 and qk_valid=0.
  - Pick the lowest index.
  - On the next edge: register the op, vj, vk and dest outputs, set RS_flag_out=1 and clear busy for that entry.
  - With no candidate: RS_flag_out=0 and the data outputs are driven to 0.
- RS_flag_out is high for exactly one cycle per issued entry.
- Latency:
  - An entry with both operands ready at issue edge k has RS_flag_out high after edge k+1.
  - A wakeup at edge k makes the entry eligible for output after edge k+1.
- Throughput: one op per cycle, with no back-pressure from the ALU (the ALU is combinational).
- The combinational loop via ALU CDB to wakeup is acceptable because wakeup only affects registered state.

Test Plan:
1. Reset, then issue ADD (op `ADD`), vj=5, vk=7, dest=3, no pending operands → RS_flag_out=1 with val1=5, val2=7, idx=3 exactly one cycle after the issue edge; RS_flag_out=0 on the following cycle.
2. Issue SUB with qj tag 6 pending and vk=2; three cycles later pulse lsb_cdb_flag_in with idx=6, val=10 → RS_flag_out rises one cycle after the pulse with val1=10, val2=2. A CDB with idx=5 before that pulse must not wake the entry.
3. Same cycle as issue with qj tag 9 pending, drive alu_cdb idx=9, val=0x80000000 → entry captured ready; dispatched next cycle with val1=0x80000000.
4. Issue 16 ready ops on consecutive cycles with dests 0..15 → full_out never asserts; outputs stream in dest order.
5. Hold all 16 entries pending (qj tag 1) → full_out=1 and a 17th issue is ignored; broadcast tag 1 once → 16 consecutive RS_flag_out pulses in entry order.
6. Fill 4 pending entries, then assert clear_in together with a new issue → all busy=0 and full_out=0; the new issue is dropped; RS_flag_out stays 0. Dropping rdy mid-stream freezes outputs and state until rdy returns.

Source files
------------

// File: rtl/rs_alu_station.sv
// Reservation station for the integer ALU. It holds dispatched micro-ops, snoops
// both CDBs to resolve pending operands, and issues the lowest ready entry each cycle.

module rs_alu_entry #(
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             wr,
  input  logic             sel,
  input  logic [5:0]       iss_op,
  input  logic             iss_qj_valid,
  input  logic [ROB_W-1:0] iss_qj,
  input  logic [31:0]      iss_vj,
  input  logic             iss_qk_valid,
  input  logic [ROB_W-1:0] iss_qk,
  input  logic [31:0]      iss_vk,
  input  logic [ROB_W-1:0] iss_dest,
  input  logic             alu_flag,
  input  logic [31:0]      alu_val,
  input  logic [ROB_W-1:0] alu_idx,
  input  logic             lsb_flag,
  input  logic [31:0]      lsb_val,
  input  logic [ROB_W-1:0] lsb_idx,
  output logic             busy,
  output logic             ready,
  output logic [5:0]       op,
  output logic [31:0]      vj,
  output logic [31:0]      vk,
  output logic [ROB_W-1:0] dest
);

  typedef struct packed {
    logic             busy;
    logic [5:0]       op;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic             qj_valid;
    logic [ROB_W-1:0] qj;
    logic             qk_valid;
    logic [ROB_W-1:0] qk;
    logic [ROB_W-1:0] dest;
  } ent_t;

  ent_t ent, ent_nxt;

  // Resolve one operand against both CDBs; the ALU bus wins if both match.
  function automatic logic [32:0] snoop(input logic pend, input logic [ROB_W-1:0] tag,
                                        input logic [31:0] val);
    logic [32:0] r;
    r = {pend, val};
    if (pend && alu_flag && tag == alu_idx)      r = {1'b0, alu_val};
    else if (pend && lsb_flag && tag == lsb_idx) r = {1'b0, lsb_val};
    return r;
  endfunction

  always_comb begin
    ent_nxt = ent;
    if (wr) begin
      ent_nxt.busy = 1'b1;
      ent_nxt.op   = iss_op;
      ent_nxt.qj   = iss_qj;
      ent_nxt.qk   = iss_qk;
      ent_nxt.dest = iss_dest;
      {ent_nxt.qj_valid, ent_nxt.vj} = snoop(iss_qj_valid, iss_qj, iss_vj);
      {ent_nxt.qk_valid, ent_nxt.vk} = snoop(iss_qk_valid, iss_qk, iss_vk);
    end else if (ent.busy) begin
      {ent_nxt.qj_valid, ent_nxt.vj} = snoop(ent.qj_valid, ent.qj, ent.vj);
      {ent_nxt.qk_valid, ent_nxt.vk} = snoop(ent.qk_valid, ent.qk, ent.vk);
      if (sel) ent_nxt.busy = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        ent <= '0;
    else if (rdy) begin
      if (clear)    ent <= '0;
      else          ent <= ent_nxt;
    end
  end

  assign busy  = ent.busy;
  assign ready = ent.busy & ~ent.qj_valid & ~ent.qk_valid;
  assign op    = ent.op;
  assign vj    = ent.vj;
  assign vk    = ent.vk;
  assign dest  = ent.dest;

endmodule

module rs_alu_station #(
  parameter int RS_SIZE  = 16,
  parameter int RS_IDX_W = 4,
  parameter int ROB_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear_in,
  input  logic             issue_flag_in,
  input  logic [5:0]       issue_op_in,
  input  logic             issue_qj_valid_in,
  input  logic [ROB_W-1:0] issue_qj_in,
  input  logic [31:0]      issue_vj_in,
  input  logic             issue_qk_valid_in,
  input  logic [ROB_W-1:0] issue_qk_in,
  input  logic [31:0]      issue_vk_in,
  input  logic [ROB_W-1:0] issue_dest_in,
  output logic             full_out,
  input  logic             alu_cdb_flag_in,
  input  logic [31:0]      alu_cdb_val_in,
  input  logic [ROB_W-1:0] alu_cdb_idx_in,
  input  logic             lsb_cdb_flag_in,
  input  logic [31:0]      lsb_cdb_val_in,
  input  logic [ROB_W-1:0] lsb_cdb_idx_in,
  output logic             RS_flag_out,
  output logic [5:0]       RS_op_out,
  output logic [31:0]      RS_val1_out,
  output logic [31:0]      RS_val2_out,
  output logic [ROB_W-1:0] RS_idx_in_ROB_out
);

  logic [RS_SIZE-1:0]            busy, ready, wr_vec, sel_vec;
  logic [RS_SIZE-1:0][5:0]       ent_op;
  logic [RS_SIZE-1:0][31:0]      ent_vj, ent_vk;
  logic [RS_SIZE-1:0][ROB_W-1:0] ent_dest;
  logic [RS_IDX_W-1:0]           sel_idx;
  logic                          sel_hit, free_hit;

  genvar g;
  generate
    for (g = 0; g < RS_SIZE; g++) begin : g_ent
      rs_alu_entry #(.ROB_W(ROB_W)) u_ent (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .clear        (clear_in),
        .wr           (wr_vec[g]),
        .sel          (sel_vec[g]),
        .iss_op       (issue_op_in),
        .iss_qj_valid (issue_qj_valid_in),
        .iss_qj       (issue_qj_in),
        .iss_vj       (issue_vj_in),
        .iss_qk_valid (issue_qk_valid_in),
        .iss_qk       (issue_qk_in),
        .iss_vk       (issue_vk_in),
        .iss_dest     (issue_dest_in),
        .alu_flag     (alu_cdb_flag_in),
        .alu_val      (alu_cdb_val_in),
        .alu_idx      (alu_cdb_idx_in),
        .lsb_flag     (lsb_cdb_flag_in),
        .lsb_val      (lsb_cdb_val_in),
        .lsb_idx      (lsb_cdb_idx_in),
        .busy         (busy[g]),
        .ready        (ready[g]),
        .op           (ent_op[g]),
        .vj           (ent_vj[g]),
        .vk           (ent_vk[g]),
        .dest         (ent_dest[g])
      );
    end
  endgenerate

  assign full_out = &busy;

  // Both pickers look at start-of-cycle busy, so a slot freed by selection
  // this cycle is only reused on the next one.
  always_comb begin
    sel_vec  = '0;
    wr_vec   = '0;
    sel_idx  = '0;
    sel_hit  = 1'b0;
    free_hit = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready[i] && !sel_hit) begin
        sel_vec[i] = 1'b1;
        sel_idx    = i[RS_IDX_W-1:0];
        sel_hit    = 1'b1;
      end
      if (!busy[i] && !free_hit) begin
        wr_vec[i] = issue_flag_in;
        free_hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (rdy && clear_in)) begin
      RS_flag_out       <= 1'b0;
      RS_op_out         <= '0;
      RS_val1_out       <= '0;
      RS_val2_out       <= '0;
      RS_idx_in_ROB_out <= '0;
    end else if (rdy) begin
      RS_flag_out       <= sel_hit;
      RS_op_out         <= sel_hit ? ent_op[sel_idx]   : '0;
      RS_val1_out       <= sel_hit ? ent_vj[sel_idx]   : '0;
      RS_val2_out       <= sel_hit ? ent_vk[sel_idx]   : '0;
      RS_idx_in_ROB_out <= sel_hit ? ent_dest[sel_idx] : '0;
    end
  end

endmodule

// File: tb/tb_rs_alu_station.sv
// Directed bench for rs_alu_station: a slot-array model of the station checked
// every cycle, plus hand-computed expectations at the key points of each scenario.

module tb_rs_alu_station;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst, rdy, clear_in, issue_flag_in;
  logic [5:0]  issue_op_in;
  logic        issue_qj_valid_in, issue_qk_valid_in;
  logic [3:0]  issue_qj_in, issue_qk_in, issue_dest_in;
  logic [31:0] issue_vj_in, issue_vk_in;
  logic        full_out;
  logic        alu_cdb_flag_in, lsb_cdb_flag_in;
  logic [31:0] alu_cdb_val_in, lsb_cdb_val_in;
  logic [3:0]  alu_cdb_idx_in, lsb_cdb_idx_in;
  logic        RS_flag_out;
  logic [5:0]  RS_op_out;
  logic [31:0] RS_val1_out, RS_val2_out;
  logic [3:0]  RS_idx_in_ROB_out;

  rs_alu_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear_in(clear_in),
    .issue_flag_in(issue_flag_in), .issue_op_in(issue_op_in),
    .issue_qj_valid_in(issue_qj_valid_in), .issue_qj_in(issue_qj_in), .issue_vj_in(issue_vj_in),
    .issue_qk_valid_in(issue_qk_valid_in), .issue_qk_in(issue_qk_in), .issue_vk_in(issue_vk_in),
    .issue_dest_in(issue_dest_in), .full_out(full_out),
    .alu_cdb_flag_in(alu_cdb_flag_in), .alu_cdb_val_in(alu_cdb_val_in), .alu_cdb_idx_in(alu_cdb_idx_in),
    .lsb_cdb_flag_in(lsb_cdb_flag_in), .lsb_cdb_val_in(lsb_cdb_val_in), .lsb_cdb_idx_in(lsb_cdb_idx_in),
    .RS_flag_out(RS_flag_out), .RS_op_out(RS_op_out), .RS_val1_out(RS_val1_out),
    .RS_val2_out(RS_val2_out), .RS_idx_in_ROB_out(RS_idx_in_ROB_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a plain slot array; each slot is either empty or holds a micro-op
  // with per-operand "still waiting on tag" markers.
  bit          m_used[N];
  logic [5:0]  m_op[N];
  logic [31:0] m_vj[N], m_vk[N];
  bit          m_wj[N], m_wk[N];
  logic [3:0]  m_tj[N], m_tk[N], m_dest[N];
  logic        e_flag;
  logic [5:0]  e_op;
  logic [31:0] e_v1, e_v2;
  logic [3:0]  e_idx;

  function automatic bit model_full();
    for (int i = 0; i < N; i++) if (!m_used[i]) return 0;
    return 1;
  endfunction

  // Returns {still_waiting, value} for one operand after looking at the buses.
  function automatic logic [32:0] bus_look(input bit w, input logic [3:0] t, input logic [31:0] v);
    if (w && alu_cdb_flag_in && t == alu_cdb_idx_in) return {1'b0, alu_cdb_val_in};
    if (w && lsb_cdb_flag_in && t == lsb_cdb_idx_in) return {1'b0, lsb_cdb_val_in};
    return {w, v};
  endfunction

  task automatic model_step();
    int pick, slot;
    bit was_full;
    if (rst || (rdy && clear_in)) begin
      for (int i = 0; i < N; i++) begin
        m_used[i] = 0; m_op[i] = 0; m_vj[i] = 0; m_vk[i] = 0;
        m_wj[i] = 0; m_wk[i] = 0; m_tj[i] = 0; m_tk[i] = 0; m_dest[i] = 0;
      end
      e_flag = 0; e_op = 0; e_v1 = 0; e_v2 = 0; e_idx = 0;
    end else if (rdy) begin
      pick = -1; slot = -1;
      was_full = model_full();
      for (int i = 0; i < N; i++) begin
        if (pick < 0 && m_used[i] && !m_wj[i] && !m_wk[i]) pick = i;
        if (slot < 0 && !m_used[i]) slot = i;
      end
      if (pick >= 0) begin
        e_flag = 1; e_op = m_op[pick]; e_v1 = m_vj[pick]; e_v2 = m_vk[pick]; e_idx = m_dest[pick];
        m_used[pick] = 0;
      end else begin
        e_flag = 0; e_op = 0; e_v1 = 0; e_v2 = 0; e_idx = 0;
      end
      for (int i = 0; i < N; i++) if (m_used[i]) begin
        {m_wj[i], m_vj[i]} = bus_look(m_wj[i], m_tj[i], m_vj[i]);
        {m_wk[i], m_vk[i]} = bus_look(m_wk[i], m_tk[i], m_vk[i]);
      end
      if (issue_flag_in && !was_full) begin
        m_used[slot] = 1; m_op[slot] = issue_op_in; m_dest[slot] = issue_dest_in;
        m_tj[slot] = issue_qj_in; m_tk[slot] = issue_qk_in;
        {m_wj[slot], m_vj[slot]} = bus_look(issue_qj_valid_in, issue_qj_in, issue_vj_in);
        {m_wk[slot], m_vk[slot]} = bus_look(issue_qk_valid_in, issue_qk_in, issue_vk_in);
      end
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) if (cmp_en) begin
    chk("cyc_flag", {31'd0, RS_flag_out}, {31'd0, e_flag});
    chk("cyc_op",   {26'd0, RS_op_out}, {26'd0, e_op});
    chk("cyc_val1", RS_val1_out, e_v1);
    chk("cyc_val2", RS_val2_out, e_v2);
    chk("cyc_idx",  {28'd0, RS_idx_in_ROB_out}, {28'd0, e_idx});
    chk("cyc_full", {31'd0, full_out}, {31'd0, model_full()});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic iss(input logic [5:0] op, input logic qjv, input logic [3:0] qj, input logic [31:0] vj,
                     input logic qkv, input logic [3:0] qk, input logic [31:0] vk, input logic [3:0] dest);
    issue_flag_in = 1; issue_op_in = op;
    issue_qj_valid_in = qjv; issue_qj_in = qj; issue_vj_in = vj;
    issue_qk_valid_in = qkv; issue_qk_in = qk; issue_vk_in = vk;
    issue_dest_in = dest;
  endtask

  task automatic no_iss();
    issue_flag_in = 0;
  endtask

  task automatic cdb_idle();
    alu_cdb_flag_in = 0; lsb_cdb_flag_in = 0;
  endtask

  task automatic chk_out(input string name, input logic f, input logic [3:0] idx,
                         input logic [31:0] v1, input logic [31:0] v2);
    chk({name, "_flag"}, {31'd0, RS_flag_out}, {31'd0, f});
    if (f) begin
      chk({name, "_idx"},  {28'd0, RS_idx_in_ROB_out}, {28'd0, idx});
      chk({name, "_val1"}, RS_val1_out, v1);
      chk({name, "_val2"}, RS_val2_out, v2);
    end
  endtask

  initial begin
    rst = 1; rdy = 1; clear_in = 0;
    issue_flag_in = 0; issue_op_in = 0; issue_qj_valid_in = 0; issue_qj_in = 0; issue_vj_in = 0;
    issue_qk_valid_in = 0; issue_qk_in = 0; issue_vk_in = 0; issue_dest_in = 0;
    alu_cdb_flag_in = 0; alu_cdb_val_in = 0; alu_cdb_idx_in = 0;
    lsb_cdb_flag_in = 0; lsb_cdb_val_in = 0; lsb_cdb_idx_in = 0;
    step(); step();
    cmp_en = 1;
    chk("rst_flag", {31'd0, RS_flag_out}, 32'd0);
    chk("rst_val1", RS_val1_out, 32'd0);
    chk("rst_full", {31'd0, full_out}, 32'd0);
    rst = 0;
    step();

    // 1: ready ADD dispatches one edge after it is written
    iss(6'd1, 0, 0, 32'd5, 0, 0, 32'd7, 4'd3);
    step(); no_iss();
    chk_out("t1_early", 0, 0, 0, 0);
    step();
    chk_out("t1_out", 1, 4'd3, 32'd5, 32'd7);
    chk("t1_op", {26'd0, RS_op_out}, 32'd1);
    step();
    chk_out("t1_after", 0, 0, 0, 0);

    // 2: wakeup via LSB bus; wrong tag ignored
    iss(6'd2, 1, 4'd6, 32'd0, 0, 0, 32'd2, 4'd4);
    step(); no_iss();
    step();
    lsb_cdb_flag_in = 1; lsb_cdb_idx_in = 4'd5; lsb_cdb_val_in = 32'd99;
    step(); cdb_idle();
    step();
    chk_out("t2_wrongtag", 0, 0, 0, 0);
    lsb_cdb_flag_in = 1; lsb_cdb_idx_in = 4'd6; lsb_cdb_val_in = 32'd10;
    step(); cdb_idle();
    chk_out("t2_wake_edge", 0, 0, 0, 0);
    step();
    chk_out("t2_out", 1, 4'd4, 32'd10, 32'd2);
    step();
    chk_out("t2_after", 0, 0, 0, 0);

    // 3: forwarding on the issue cycle
    iss(6'd3, 1, 4'd9, 32'd0, 0, 0, 32'd1, 4'd5);
    alu_cdb_flag_in = 1; alu_cdb_idx_in = 4'd9; alu_cdb_val_in = 32'h8000_0000;
    step(); no_iss(); cdb_idle();
    step();
    chk_out("t3_out", 1, 4'd5, 32'h8000_0000, 32'd1);
    step();

    // 4: 16 back-to-back ready ops stream out in order, never full
    for (int d = 0; d < 16; d++) begin
      iss(6'd4, 0, 0, d, 0, 0, d * 2, d[3:0]);
      step();
      if (d > 0) chk_out("t4_stream", 1, 4'(d - 1), d - 1, (d - 1) * 2);
      chk("t4_full", {31'd0, full_out}, 32'd0);
    end
    no_iss();
    step();
    chk_out("t4_last", 1, 4'd15, 32'd15, 32'd30);
    step();
    chk_out("t4_drain", 0, 0, 0, 0);

    // 5: fill with pending ops, reject a 17th, then wake all at once
    for (int d = 0; d < 16; d++) begin
      iss(6'd5, 1, 4'd1, 0, 0, 0, d, d[3:0]);
      step();
    end
    no_iss();
    chk("t5_full", {31'd0, full_out}, 32'd1);
    iss(6'd6, 0, 0, 32'd77, 0, 0, 32'd88, 4'd7);
    step(); no_iss();
    chk("t5_full_hold", {31'd0, full_out}, 32'd1);
    step();
    chk_out("t5_ignored", 0, 0, 0, 0);
    alu_cdb_flag_in = 1; alu_cdb_idx_in = 4'd1; alu_cdb_val_in = 32'h55;
    step(); cdb_idle();
    for (int i = 0; i < 16; i++) begin
      step();
      chk_out("t5_burst", 1, 4'(i), 32'h55, i);
    end
    step();
    chk_out("t5_drain", 0, 0, 0, 0);
    chk("t5_empty", {31'd0, full_out}, 32'd0);

    // 6a: clear drops pending entries and a same-cycle issue
    for (int d = 0; d < 4; d++) begin
      iss(6'd7, 1, 4'd2, 0, 0, 0, d, d[3:0]);
      step();
    end
    iss(6'd8, 0, 0, 32'd1, 0, 0, 32'd2, 4'd9);
    clear_in = 1;
    step(); clear_in = 0; no_iss();
    chk_out("t6_clear", 0, 0, 0, 0);
    step();
    chk_out("t6_dropped", 0, 0, 0, 0);
    alu_cdb_flag_in = 1; alu_cdb_idx_in = 4'd2; alu_cdb_val_in = 32'd3;
    step(); cdb_idle();
    step();
    chk_out("t6_gone", 0, 0, 0, 0);

    // 6b: rdy low freezes outputs and ignores issue
    iss(6'd9, 0, 0, 32'd10, 0, 0, 32'd20, 4'd10);
    step();
    iss(6'd9, 0, 0, 32'd11, 0, 0, 32'd21, 4'd11);
    step();
    iss(6'd9, 0, 0, 32'd12, 0, 0, 32'd22, 4'd12);
    step();
    chk_out("t6_pre", 1, 4'd11, 32'd11, 32'd21);
    iss(6'd9, 0, 0, 32'd13, 0, 0, 32'd23, 4'd13);
    rdy = 0;
    step();
    chk_out("t6_freeze1", 1, 4'd11, 32'd11, 32'd21);
    step();
    chk_out("t6_freeze2", 1, 4'd11, 32'd11, 32'd21);
    no_iss(); rdy = 1;
    step();
    chk_out("t6_resume", 1, 4'd12, 32'd12, 32'd22);
    step();
    chk_out("t6_end", 0, 0, 0, 0);
    step();

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
